alu_exec: RTL and testbench

Registered execute stage that consumes the 3-bit `alucont` code produced by the ALU control decoder and carries out the selected operation on two operands. It drives a one-entry valid/ready output register with result, write-back enable and error. It also holds the processor status flags (C, L, F, Z, N) and updates them per operation. It sits between decode/register-read and register write-back.

---
 rtl/alu_exec.sv | 139 +++++++++++++
 tb/tb_alu_exec.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Registered ALU execute stage: one-entry valid/ready output register plus the
// processor status flags {C, L, F, Z, N}, updated only on accepted operations.
module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucont,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_en,
  output logic             err,
  output logic [4:0]       flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wb_en_q, wb_en_d;
  logic             err_q, err_d;
  logic [4:0]       flags_q, flags_d;

  logic             accept;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] op_res;
  logic             op_wb, op_err;
  logic [4:0]       op_flags;
  logic             a_msb, b_msb;

  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign a_msb    = a[WIDTH-1];
  assign b_msb    = b[WIDTH-1];

  always_comb begin
    op_res   = '0;
    op_wb    = 1'b0;
    op_err   = 1'b0;
    op_flags = flags_q;
    case (alucont)
      OP_ADD: begin
        op_res       = sum_ext[WIDTH-1:0];
        op_wb        = 1'b1;
        op_flags[FC] = sum_ext[WIDTH];
        op_flags[FF] = (a_msb == b_msb) && (op_res[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        op_res       = diff_ext[WIDTH-1:0];
        op_wb        = 1'b1;
        op_flags[FC] = diff_ext[WIDTH];
        op_flags[FF] = (a_msb != b_msb) && (op_res[WIDTH-1] != a_msb);
      end
      OP_AND: begin
        op_res = a & b;
        op_wb  = 1'b1;
      end
      OP_XOR: begin
        op_res = a ^ b;
        op_wb  = 1'b1;
      end
      OP_OR: begin
        op_res = a | b;
        op_wb  = 1'b1;
      end
      OP_CMP: begin
        op_res       = a;
        op_flags[FZ] = (a == b);
        op_flags[FL] = diff_ext[WIDTH];
        op_flags[FN] = ($signed(a) < $signed(b));
      end
      default: op_err = 1'b1;
    endcase
    // Every write-back op derives Z and N from its result
    if (op_wb) begin
      op_flags[FZ] = (op_res == '0);
      op_flags[FN] = op_res[WIDTH-1];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    wb_en_d     = wb_en_q;
    err_d       = err_q;
    flags_d     = flags_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = op_res;
      wb_en_d     = op_wb;
      err_d       = op_err;
      flags_d     = op_flags;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      wb_en_q     <= 1'b0;
      err_q       <= 1'b0;
      flags_q     <= 5'b00000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wb_en_q     <= wb_en_d;
      err_q       <= err_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign wb_en     = wb_en_q;
  assign err       = err_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed table, hand-written handshake sequences and
// random traffic, all checked against an arithmetic reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alucont;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        wb_en;
  logic        err;
  logic [4:0]  flags;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic        m_valid;
  logic [15:0] m_res;
  logic        m_wb, m_err;
  logic [4:0]  m_flags;

  alu_exec #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucont(alucont), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .wb_en(wb_en), .err(err),
    .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        wb;
    logic        er;
    logic [4:0]  fl;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Flags {C,L,F,Z,N} computed with integer arithmetic from the operation rules.
  task automatic ref_op(input logic [2:0] code, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [4:0] fin, output logic [15:0] res, output logic wb,
                        output logic er, output logic [4:0] fout);
    int ua, ub, sa, sb, s, ss;
    logic c, l, f, z, n;
    ua = ia; ub = ib;
    sa = $signed(ia); sb = $signed(ib);
    {c, l, f, z, n} = fin;
    res = 16'h0; wb = 1'b0; er = 1'b0;
    case (code)
      3'd0: begin
        s = ua + ub; ss = sa + sb;
        res = 16'(s % 65536); wb = 1'b1;
        c = (s > 65535); f = (ss > 32767) || (ss < -32768);
      end
      3'd1: begin
        s = ua - ub + 65536; ss = sa - sb;
        res = 16'(s % 65536); wb = 1'b1;
        c = (ua < ub); f = (ss > 32767) || (ss < -32768);
      end
      3'd2: begin res = ia & ib; wb = 1'b1; end
      3'd3: begin res = ia ^ ib; wb = 1'b1; end
      3'd4: begin res = ia | ib; wb = 1'b1; end
      3'd5: begin
        res = ia; z = (ua == ub); l = (ua < ub); n = (sa < sb);
      end
      default: er = 1'b1;
    endcase
    if (wb) begin
      z = (res == 16'h0);
      n = (int'(res) >= 32768);
    end
    fout = {c, l, f, z, n};
  endtask

  // One clock: drive inputs, check in_ready, advance model, compare after the edge.
  task automatic step(input logic rst, input logic iv, input logic [2:0] code,
                      input logic [15:0] ia, input logic [15:0] ib, input logic ordy);
    logic acc, exp_rdy;
    logic [15:0] r; logic w, e; logic [4:0] fo;
    reset = rst; in_valid = iv; alucont = code; a = ia; b = ib; out_ready = ordy;
    #1;
    exp_rdy = !rst && (!m_valid || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    if (rst) begin
      m_valid = 1'b0; m_res = 16'h0; m_wb = 1'b0; m_err = 1'b0; m_flags = 5'b0;
    end else if (acc) begin
      ref_op(code, ia, ib, m_flags, r, w, e, fo);
      m_valid = 1'b1; m_res = r; m_wb = w; m_err = e; m_flags = fo;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("result", 32'(result), 32'(m_res));
    check("wb_en", 32'(wb_en), 32'(m_wb));
    check("err", 32'(err), 32'(m_err));
    check("flags", 32'(flags), 32'(m_flags));
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 5'b00101};
    tbl[1]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 5'b10001};
    tbl[2]  = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 5'b00010};
    tbl[3]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 5'b00101};
    tbl[4]  = '{3'd5, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 5'b00101};
    tbl[5]  = '{3'd5, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 5'b01100};
    tbl[6]  = '{3'd6, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 5'b01100};
    tbl[7]  = '{3'd2, 16'h0F0F, 16'h00FF, 16'h000F, 1'b1, 1'b0, 5'b01100};
    tbl[8]  = '{3'd3, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 5'b01100};
    tbl[9]  = '{3'd4, 16'hF000, 16'h000F, 16'hF00F, 1'b1, 1'b0, 5'b01101};
    tbl[10] = '{3'd7, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b1, 5'b01101};
    tbl[11] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 5'b11010};
    tbl[12] = '{3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 5'b11110};
    tbl[13] = '{3'd5, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0, 5'b10110};

    m_valid = 1'b0; m_res = 16'h0; m_wb = 1'b0; m_err = 1'b0; m_flags = 5'b0;
    reset = 1'b1; in_valid = 1'b0; alucont = 3'd0; a = 16'h0; b = 16'h0; out_ready = 1'b0;

    // reset state
    step(1'b1, 1'b1, 3'd0, 16'h1111, 16'h2222, 1'b1);
    step(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1);

    // directed table, streamed one op per cycle
    foreach (tbl[i]) begin
      step(1'b0, 1'b1, tbl[i].code, tbl[i].a, tbl[i].b, 1'b1);
      check("tbl_valid", 32'(out_valid), 32'd1);
      check("tbl_result", 32'(result), 32'(tbl[i].res));
      check("tbl_wb_en", 32'(wb_en), 32'(tbl[i].wb));
      check("tbl_err", 32'(err), 32'(tbl[i].er));
      check("tbl_flags", 32'(flags), 32'(tbl[i].fl));
    end

    // drain, then idle: flags must not move
    step(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b1);
    check("idle_flags", 32'(flags), 32'(5'b10110));

    // backpressure: and accepted, then 3 stalled cycles, then or accepted on release
    step(1'b0, 1'b1, 3'd2, 16'h0F0F, 16'h00FF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd4, 16'hF000, 16'h000F, 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result", 32'(result), 32'h000F);
    end
    step(1'b0, 1'b1, 3'd4, 16'hF000, 16'h000F, 1'b1);
    check("bp_release", 32'(result), 32'hF00F);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 3'd0, 16'(i * 16'h1001), 16'h0101, 1'b1);

    // reset while holding an unconsumed result under backpressure
    step(1'b0, 1'b1, 3'd1, 16'h0001, 16'h0002, 1'b0);
    step(1'b1, 1'b1, 3'd0, 16'h7FFF, 16'h7FFF, 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    step(1'b0, 1'b1, 3'd3, 16'h00FF, 16'h0F0F, 1'b1);
    check("post_rst", 32'(result), 32'h0FF0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
           ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
